// File: rtl/sdrc_app_txn_checker_if.sv
// Application-side request/beat bundle observed by the SDRAM controller txn checker.
interface sdrc_app_txn_checker_if #(
  parameter int APP_AW = 26,
  parameter int bl     = 9
);
  logic              app_req;
  logic [APP_AW-1:0] app_req_addr;
  logic [bl-1:0]     app_req_len;
  logic              app_req_wr_n;
  logic              app_req_ack;
  logic              app_wr_next_req;
  logic              app_last_wr;
  logic              app_rd_valid;
  logic              app_last_rd;

  modport master (
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_ack,
    output app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd
  );

  modport slave (
    input app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_ack,
    input app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd
  );
endinterface

// File: rtl/sdrc_app_txn_checker.sv
// Protocol checker for the SDRAM controller app interface: request handshake,
// per-direction burst length/last tracking, sticky error flags and txn counters.
module sdrc_app_txn_checker #(
  parameter int APP_AW      = 26,
  parameter int bl          = 9,
  parameter int QDEPTH      = 4,
  parameter int REQ_TIMEOUT = 1024
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_resetn,
  sdrc_app_txn_checker_if.slave    app,
  input  logic                     err_clr,
  output logic [7:0]               err_vec,
  output logic                     err_any,
  output logic [15:0]              wr_txn_cnt,
  output logic [15:0]              rd_txn_cnt,
  output logic [$clog2(QDEPTH):0]  wr_pend,
  output logic [$clog2(QDEPTH):0]  rd_pend
);
  localparam int QW = $clog2(QDEPTH);
  localparam int TW = $clog2(REQ_TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} req_state_t;

  req_state_t        r_state, w_state_nxt;
  logic [APP_AW-1:0] r_cap_addr;
  logic [bl-1:0]     r_cap_len;
  logic              r_cap_wr_n;
  logic [TW-1:0]     r_tcnt;
  logic              w_accept, w_unstable, w_spur, w_zero, w_tout, w_pend_stay;
  logic [1:0]        w_push_req, w_beat, w_last, w_orph, w_lerr, w_ovf;
  logic [7:0]        r_err, w_err_set, w_err_nxt;
  logic              r_any;
  logic [15:0]       w_txn  [2];
  logic [QW:0]       w_pend [2];

  assign w_accept      = app.app_req & app.app_req_ack;
  assign w_zero        = w_accept & (app.app_req_len == '0);
  assign w_spur        = app.app_req_ack & ~app.app_req;
  assign w_push_req[0] = w_accept & ~w_zero & ~app.app_req_wr_n;
  assign w_push_req[1] = w_accept & ~w_zero &  app.app_req_wr_n;
  assign w_beat        = {app.app_rd_valid, app.app_wr_next_req};
  assign w_last        = {app.app_last_rd,  app.app_last_wr};

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_unstable  = 1'b0;
    case (r_state)
      S_IDLE: if (app.app_req && !app.app_req_ack) w_state_nxt = S_PEND;
      S_PEND: begin
        if (!app.app_req) begin
          w_state_nxt = S_IDLE;
          w_unstable  = ~app.app_req_ack;
        end else begin
          w_unstable = (app.app_req_addr != r_cap_addr) |
                       (app.app_req_len  != r_cap_len)  |
                       (app.app_req_wr_n != r_cap_wr_n);
          if (app.app_req_ack) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are latched every idle cycle so the PEND-entry values are held.
  always_ff @(posedge sdram_clk) begin
    if (r_state == S_IDLE) begin
      r_cap_addr <= app.app_req_addr;
      r_cap_len  <= app.app_req_len;
      r_cap_wr_n <= app.app_req_wr_n;
    end
  end

  assign w_pend_stay = (r_state == S_PEND) && (w_state_nxt == S_PEND);
  assign w_tout      = w_pend_stay && (r_tcnt == TW'(REQ_TIMEOUT - 1));

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn)                  r_tcnt <= '0;
    else if (!w_pend_stay)              r_tcnt <= '0;
    else if (r_tcnt != TW'(REQ_TIMEOUT)) r_tcnt <= r_tcnt + TW'(1);
  end

  // Index 0 tracks writes, index 1 tracks reads; the queue head is the active burst.
  for (genvar d = 0; d < 2; d++) begin : g_dir
    logic [bl-1:0] r_mem [QDEPTH];
    logic [QW:0]   r_wptr, r_rptr, w_cnt;
    logic [bl-1:0] r_rem, w_rem_q, w_rem_eff;
    logic [15:0]   r_txn;
    logic          w_full, w_pop, w_push;

    assign w_cnt     = r_wptr - r_rptr;
    assign w_full    = (w_cnt == (QW+1)'(QDEPTH));
    assign w_rem_q   = (r_rem != '0) ? r_rem :
                       (w_cnt != '0) ? r_mem[r_rptr[QW-1:0]] : '0;
    // Empty queue and a same-cycle accept: the beat counts against the incoming len.
    assign w_rem_eff = ((w_rem_q == '0) && w_push_req[d]) ? app.app_req_len : w_rem_q;
    assign w_pop     = w_beat[d] && (w_rem_eff == bl'(1));
    assign w_push    = w_push_req[d] && (!w_full || w_pop);

    assign w_ovf[d]  = w_push_req[d] && w_full && !w_pop;
    assign w_orph[d] = w_beat[d] && (w_rem_eff == '0);
    assign w_lerr[d] = w_beat[d] && (w_rem_eff != '0) && (w_last[d] != (w_rem_eff == bl'(1)));

    always_ff @(posedge sdram_clk) begin
      if (w_push) r_mem[r_wptr[QW-1:0]] <= app.app_req_len;
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_rem  <= '0;
        r_txn  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + (QW+1)'(1);
        if (w_pop)  r_rptr <= r_rptr + (QW+1)'(1);
        if (w_beat[d] && (w_rem_eff != '0)) r_rem <= w_rem_eff - bl'(1);
        else                                r_rem <= w_rem_q;
        if (w_pop && (r_txn != 16'hFFFF))   r_txn <= r_txn + 16'd1;
      end
    end

    assign w_txn[d]  = r_txn;
    assign w_pend[d] = w_cnt;
  end

  assign w_err_set = {|w_ovf, |w_orph, w_lerr[1], w_lerr[0], w_tout, w_zero, w_spur, w_unstable};
  assign w_err_nxt = (err_clr ? 8'h00 : r_err) | w_err_set;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_err <= '0;
      r_any <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
      r_any <= |w_err_nxt;
    end
  end

  assign err_vec    = r_err;
  assign err_any    = r_any;
  assign wr_txn_cnt = w_txn[0];
  assign rd_txn_cnt = w_txn[1];
  assign wr_pend    = w_pend[0];
  assign rd_pend    = w_pend[1];
endmodule

// File: tb/tb_sdrc_app_txn_checker.sv
// Bench for sdrc_app_txn_checker: directed scenarios plus random traffic against a queue-based model.
module tb_sdrc_app_txn_checker;
  localparam int APP_AW      = 26;
  localparam int BL          = 9;
  localparam int QDEPTH      = 4;
  localparam int REQ_TIMEOUT = 1024;

  logic        sdram_clk = 1'b0;
  logic        sdram_resetn = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  err_vec;
  logic        err_any;
  logic [15:0] wr_txn_cnt, rd_txn_cnt;
  logic [2:0]  wr_pend, rd_pend;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  sdrc_app_txn_checker_if #(.APP_AW(APP_AW), .bl(BL)) app_if ();

  sdrc_app_txn_checker #(.APP_AW(APP_AW), .bl(BL), .QDEPTH(QDEPTH), .REQ_TIMEOUT(REQ_TIMEOUT)) dut (
    .sdram_clk    (sdram_clk),
    .sdram_resetn (sdram_resetn),
    .app          (app_if.slave),
    .err_clr      (err_clr),
    .err_vec      (err_vec),
    .err_any      (err_any),
    .wr_txn_cnt   (wr_txn_cnt),
    .rd_txn_cnt   (rd_txn_cnt),
    .wr_pend      (wr_pend),
    .rd_pend      (rd_pend)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Reference model: per-direction list of outstanding burst lengths plus beats seen on the head.
  int          mq [2][$];
  int          m_done [2];
  int          m_cnt [2];
  bit [7:0]    m_err;
  bit          m_pending;
  int          m_age;
  logic [APP_AW-1:0] m_addr;
  logic [BL-1:0]     m_len;
  logic              m_wr_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      m_done[d] = 0;
      m_cnt[d]  = 0;
    end
    m_err = '0;
    m_pending = 1'b0;
    m_age = 0;
  endtask

  function automatic bit exp_last(input int d);
    if (mq[d].size() == 0) return 1'b0;
    return (mq[d][0] - m_done[d]) == 1;
  endfunction

  task automatic model_step();
    bit [7:0] e = '0;
    bit acc = app_if.app_req & app_if.app_req_ack;
    int len = int'(app_if.app_req_len);
    if (app_if.app_req_ack && !app_if.app_req) e[1] = 1'b1;
    if (m_pending) begin
      if (!app_if.app_req) begin
        if (!app_if.app_req_ack) e[0] = 1'b1;
        m_pending = 1'b0;
      end else begin
        if (app_if.app_req_addr != m_addr || app_if.app_req_len != m_len ||
            app_if.app_req_wr_n != m_wr_n) e[0] = 1'b1;
        if (app_if.app_req_ack) m_pending = 1'b0;
        else begin
          m_age++;
          if (m_age == REQ_TIMEOUT) e[3] = 1'b1;
        end
      end
    end else if (app_if.app_req && !app_if.app_req_ack) begin
      m_pending = 1'b1;
      m_age  = 0;
      m_addr = app_if.app_req_addr;
      m_len  = app_if.app_req_len;
      m_wr_n = app_if.app_req_wr_n;
    end
    if (acc && len == 0) e[2] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      bit beat = (d == 0) ? app_if.app_wr_next_req : app_if.app_rd_valid;
      bit last = (d == 0) ? app_if.app_last_wr : app_if.app_last_rd;
      bit want = acc && (int'(app_if.app_req_wr_n) == d) && (len != 0);
      bit done = 1'b0;
      int left;
      if (mq[d].size() > 0) left = mq[d][0] - m_done[d];
      else if (want)        left = len;
      else                  left = 0;
      if (beat) begin
        if (left == 0) e[6] = 1'b1;
        else begin
          if (last != (left == 1)) e[4+d] = 1'b1;
          done = (left == 1);
        end
      end
      if (want) begin
        if (mq[d].size() == QDEPTH && !done) e[7] = 1'b1;
        else mq[d].push_back(len);
      end
      if (beat && left != 0) begin
        if (done) begin
          void'(mq[d].pop_front());
          m_done[d] = 0;
          if (m_cnt[d] < 65535) m_cnt[d]++;
        end else m_done[d]++;
      end
    end
    m_err = (err_clr ? 8'h00 : m_err) | e;
  endtask

  task automatic step();
    model_step();
    @(posedge sdram_clk);
    #1;
    check_eq("err_vec", 32'(err_vec), 32'(m_err));
    check_eq("err_any", 32'(err_any), 32'(|m_err));
    check_eq("wr_pend", 32'(wr_pend), 32'(mq[0].size()));
    check_eq("rd_pend", 32'(rd_pend), 32'(mq[1].size()));
    check_eq("wr_cnt",  32'(wr_txn_cnt), 32'(m_cnt[0]));
    check_eq("rd_cnt",  32'(rd_txn_cnt), 32'(m_cnt[1]));
  endtask

  task automatic idle_in();
    app_if.app_req = 1'b0;
    app_if.app_req_ack = 1'b0;
    app_if.app_req_addr = '0;
    app_if.app_req_len = '0;
    app_if.app_req_wr_n = 1'b0;
    app_if.app_wr_next_req = 1'b0;
    app_if.app_last_wr = 1'b0;
    app_if.app_rd_valid = 1'b0;
    app_if.app_last_rd = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic accept(input bit wr_n, input int len);
    idle_in();
    app_if.app_req = 1'b1;
    app_if.app_req_ack = 1'b1;
    app_if.app_req_wr_n = wr_n;
    app_if.app_req_len = BL'(len);
    step();
    idle_in();
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_err"},  32'(err_vec), 32'h0);
    check_eq({tag, "_any"},  32'(err_any), 32'h0);
    check_eq({tag, "_wrc"},  32'(wr_txn_cnt), 32'h0);
    check_eq({tag, "_rdc"},  32'(rd_txn_cnt), 32'h0);
    check_eq({tag, "_wrp"},  32'(wr_pend), 32'h0);
    check_eq({tag, "_rdp"},  32'(rd_pend), 32'h0);
  endtask

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(posedge sdram_clk);
    #1;
    check_zero("rst");
    sdram_resetn = 1'b1;

    // Write len=4 completes cleanly
    accept(1'b0, 4);
    check_eq("s1_pend1", 32'(wr_pend), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      app_if.app_wr_next_req = 1'b1;
      app_if.app_last_wr = (i == 4);
      step();
    end
    idle_in();
    check_eq("s1_cnt",  32'(wr_txn_cnt), 32'd1);
    check_eq("s1_pend0", 32'(wr_pend), 32'd0);
    check_eq("s1_err",  32'(err_vec), 32'h0);

    // Read len=2 with early last
    accept(1'b1, 2);
    app_if.app_rd_valid = 1'b1;
    app_if.app_last_rd = 1'b1;
    step();
    check_eq("s2_err5", 32'(err_vec[5]), 32'd1);
    step();
    idle_in();
    check_eq("s2_pend", 32'(rd_pend), 32'd0);
    check_eq("s2_cnt",  32'(rd_txn_cnt), 32'd1);
    err_clr = 1'b1;
    step();
    idle_in();

    // Address changes while pending
    app_if.app_req = 1'b1;
    app_if.app_req_addr = 26'h100;
    step();
    app_if.app_req_addr = 26'h104;
    step();
    check_eq("s3_err0", 32'(err_vec), 32'h01);
    idle_in();
    step();
    err_clr = 1'b1;
    step();
    idle_in();
    check_eq("s3_clr", 32'(err_vec), 32'h0);

    // Read queue overflow then drain
    for (int i = 0; i < 5; i++) accept(1'b1, 8);
    check_eq("s4_pend", 32'(rd_pend), 32'd4);
    check_eq("s4_ovf",  32'(err_vec), 32'h80);
    err_clr = 1'b1;
    step();
    idle_in();
    for (int i = 1; i <= 32; i++) begin
      app_if.app_rd_valid = 1'b1;
      app_if.app_last_rd = (i % 8 == 0);
      step();
    end
    idle_in();
    check_eq("s4_cnt", 32'(rd_txn_cnt), 32'd5);
    check_eq("s4_err", 32'(err_vec), 32'h0);
    check_eq("s4_pend0", 32'(rd_pend), 32'd0);

    // Request timeout and spurious ack
    app_if.app_req = 1'b1;
    app_if.app_req_wr_n = 1'b1;
    app_if.app_req_len = 9'd1;
    for (int i = 1; i <= REQ_TIMEOUT; i++) step();
    check_eq("s5_pre", 32'(err_vec[3]), 32'd0);
    step();
    check_eq("s5_tout", 32'(err_vec[3]), 32'd1);
    idle_in();
    step();
    err_clr = 1'b1;
    step();
    idle_in();
    app_if.app_req_ack = 1'b1;
    step();
    idle_in();
    check_eq("s5_spur", 32'(err_vec), 32'h02);
    err_clr = 1'b1;
    step();
    idle_in();

    // Reset in the middle of a write burst
    accept(1'b0, 5);
    app_if.app_wr_next_req = 1'b1;
    step();
    step();
    idle_in();
    check_eq("s6_pend", 32'(wr_pend), 32'd1);
    sdram_resetn = 1'b0;
    #1;
    model_reset();
    check_zero("s6_rst");
    @(negedge sdram_clk);
    sdram_resetn = 1'b1;
    accept(1'b0, 1);
    app_if.app_wr_next_req = 1'b1;
    app_if.app_last_wr = 1'b1;
    step();
    idle_in();
    check_eq("s6_cnt", 32'(wr_txn_cnt), 32'd1);
    check_eq("s6_err", 32'(err_vec), 32'h0);
    // Same-cycle accept and single beat on an empty queue
    app_if.app_req = 1'b1;
    app_if.app_req_ack = 1'b1;
    app_if.app_req_len = 9'd1;
    app_if.app_wr_next_req = 1'b1;
    app_if.app_last_wr = 1'b1;
    step();
    idle_in();
    check_eq("s6_byp", 32'(wr_txn_cnt), 32'd2);
    check_eq("s6_byp_err", 32'(err_vec), 32'h0);
    check_eq("s6_byp_pend", 32'(wr_pend), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bit was_acc = app_if.app_req & app_if.app_req_ack;
      if (!app_if.app_req || was_acc) begin
        app_if.app_req = ($urandom % 3 == 0);
        app_if.app_req_addr = APP_AW'($urandom);
        app_if.app_req_len = BL'($urandom_range(0, 6));
        app_if.app_req_wr_n = 1'($urandom % 2);
      end else begin
        if ($urandom % 40 == 0) app_if.app_req_addr = app_if.app_req_addr ^ 26'h1;
        if ($urandom % 60 == 0) app_if.app_req = 1'b0;
      end
      app_if.app_req_ack = app_if.app_req ? ($urandom % 3 == 0) : ($urandom % 60 == 0);
      app_if.app_wr_next_req = 1'($urandom % 2);
      app_if.app_rd_valid = 1'($urandom % 2);
      app_if.app_last_wr = ($urandom % 10 == 0) ? 1'($urandom % 2) : exp_last(0);
      app_if.app_last_rd = ($urandom % 10 == 0) ? 1'($urandom % 2) : exp_last(1);
      err_clr = ($urandom % 16 == 0);
      step();
    end
    idle_in();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
